// File: rtl/fmdll_pkg.sv
// fmdll_pkg: shared types and defaults for the FMDLL lock controller.
package fmdll_pkg;

  // Default width of the delay-line control code.
  localparam int CODE_W_DEF = 6;

  // Lock controller operating states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Direction of the last code adjustment (used by the binary search).
  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/fmdll_sync_bus.sv
// fmdll_sync_bus: two-flop synchronizer per bit followed by a stability
// register. The bus is only trusted when two consecutive synchronized
// values agree, which filters samples taken while the source counter moved.
module fmdll_sync_bus #(
  parameter int W = 4
) (
  input  logic         clk_ext,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  logic [W-1:0] sync2_bus;
  logic [W-1:0] stab_reg;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic sync1_reg;
      logic sync2_reg;

      // Two-flop metastability filter for one bit of the bus.
      always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= din[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign sync2_bus[gi] = sync2_reg;
    end
  endgenerate

  // Hold the previous synchronized word so it can be compared with the newest.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      stab_reg <= '0;
    end else begin
      stab_reg <= sync2_bus;
    end
  end

  assign dout  = stab_reg;
  assign valid = (sync2_bus == stab_reg);

endmodule

// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl: steps the delay-line code until the clk_out count per
// reference window equals N, then asserts lock/Sel; drops lock after a run
// of misses. Optional macro FMDLL_LOCK_CTRL_BINSRCH_EN selects a binary
// search step (halving on each direction reversal) instead of a fixed step.
module fmdll_lock_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int CODE_INIT = 32,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 2
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic [1:0]        M,
  input  logic [3:0]        N,
  input  logic [1:0]        M_counter,
  input  logic [3:0]        N_counter,
  output logic [CODE_W-1:0] dly_code,
  output logic              Sel,
  output logic              lock,
  output logic              sat
);

  localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] STEP_MIN = CODE_W'(1);
  localparam logic [3:0]        LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]        LOSS_TGT = 4'(LOSS_CNT);

  logic [3:0]        samp;
  logic              samp_vld;
  logic [1:0]        m_cnt_reg;
  logic              win_end;
  state_t            state_reg, state_next;
  logic [3:0]        hit_cnt_reg, hit_cnt_next;
  logic [3:0]        miss_cnt_reg, miss_cnt_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic              sat_reg, sat_next;
  logic              move_up, move_dn;
  logic [CODE_W-1:0] eff_step;
  logic [CODE_W:0]   sum_ext;

  fmdll_sync_bus #(.W(4)) u_sync (
    .clk_ext (clk_ext),
    .rst_n   (rst_n),
    .din     (N_counter),
    .dout    (samp),
    .valid   (samp_vld)
  );

  // Window end: counter wrapped from M back to 1.
  assign win_end = (m_cnt_reg == M) && (M_counter == 2'd1);

  // Decision logic: evaluated once per window, only on a trustworthy sample.
  always_comb begin
    state_next    = state_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    move_up       = 1'b0;
    move_dn       = 1'b0;
    if (win_end && samp_vld) begin
      case (state_reg)
        IDLE: state_next = ADJUST;
        ADJUST: begin
          if (samp == N) begin
            if (hit_cnt_reg + 4'd1 == LOCK_TGT) begin
              state_next    = LOCKED;
              hit_cnt_next  = '0;
              miss_cnt_next = '0;
            end else begin
              hit_cnt_next = hit_cnt_reg + 4'd1;
            end
          end else if (samp == 4'd0) begin
            move_up      = 1'b1;
            hit_cnt_next = '0;
          end else if (samp < N) begin
            move_dn      = 1'b1;
            hit_cnt_next = '0;
          end else begin
            hit_cnt_next = '0;
          end
        end
        LOCKED: begin
          if (samp == N) begin
            miss_cnt_next = '0;
          end else if (miss_cnt_reg + 4'd1 == LOSS_TGT) begin
            state_next    = ADJUST;
            miss_cnt_next = '0;
            hit_cnt_next  = '0;
          end else begin
            miss_cnt_next = miss_cnt_reg + 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef FMDLL_LOCK_CTRL_BINSRCH_EN
  localparam logic [CODE_W-1:0] STEP_INIT = STEP_MIN << (CODE_W - 2);

  logic [CODE_W-1:0] step_reg, step_next;
  dir_t              dir_reg, dir_next, req_dir;
  logic              dir_vld_reg, dir_vld_next;
  logic              leave_lock;

  assign leave_lock = (state_reg == LOCKED) && (state_next == ADJUST);

  // Search step size and last adjust direction.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      step_reg    <= STEP_INIT;
      dir_reg     <= DIR_UP;
      dir_vld_reg <= 1'b0;
    end else begin
      step_reg    <= step_next;
      dir_reg     <= dir_next;
      dir_vld_reg <= dir_vld_next;
    end
  end
`endif

  // Step arithmetic one bit wider than the code so over/underflow is visible.
  always_comb begin
    code_next = code_reg;
    sat_next  = 1'b0;
`ifdef FMDLL_LOCK_CTRL_BINSRCH_EN
    step_next    = step_reg;
    dir_next     = dir_reg;
    dir_vld_next = dir_vld_reg;
    req_dir      = move_up ? DIR_UP : DIR_DN;
    eff_step     = step_reg;
    if (dir_vld_reg && (req_dir != dir_reg) && (step_reg > STEP_MIN)) begin
      eff_step = step_reg >> 1;
    end
`else
    eff_step = STEP_MIN;
`endif
    sum_ext = move_up ? ({1'b0, code_reg} + {1'b0, eff_step})
                      : ({1'b0, code_reg} - {1'b0, eff_step});
    if (move_up || move_dn) begin
      if (sum_ext[CODE_W]) begin
        code_next = move_up ? {CODE_W{1'b1}} : {CODE_W{1'b0}};
        sat_next  = 1'b1;
      end else begin
        code_next = sum_ext[CODE_W-1:0];
      end
`ifdef FMDLL_LOCK_CTRL_BINSRCH_EN
      step_next    = eff_step;
      dir_next     = req_dir;
      dir_vld_next = 1'b1;
`endif
    end
`ifdef FMDLL_LOCK_CTRL_BINSRCH_EN
    if (leave_lock) begin
      step_next    = STEP_INIT;
      dir_vld_next = 1'b0;
    end
`endif
  end

  // Main state register: window tracker, FSM, counters, code and sat pulse.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt_reg    <= '0;
      state_reg    <= IDLE;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      code_reg     <= CODE_RST;
      sat_reg      <= 1'b0;
    end else begin
      m_cnt_reg    <= M_counter;
      state_reg    <= state_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      code_reg     <= code_next;
      sat_reg      <= sat_next;
    end
  end

  assign dly_code = code_reg;
  assign sat      = sat_reg;
  assign lock     = (state_reg == LOCKED);
  assign Sel      = (state_reg == LOCKED);

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb_fmdll_lock_ctrl: directed scenarios plus randomized windows, every
// cycle compared against a behavioural model of the lock controller.
`timescale 1ns/1ps
module tb_fmdll_lock_ctrl;

  localparam int CODE_W    = 6;
  localparam int CODE_INIT = 32;
  localparam int LOCK_CNT  = 4;
  localparam int LOSS_CNT  = 2;
  localparam int CODE_MAX  = (1 << CODE_W) - 1;

  logic              clk_ext = 1'b0;
  logic              rst_n;
  logic [1:0]        M, M_counter;
  logic [3:0]        N, N_counter;
  logic [CODE_W-1:0] dly_code;
  logic              Sel, lock, sat;

  int total = 0;
  int bad   = 0;
  int win_idx = 0;
  int next_m = 3;
  int next_n = 4;

  // Behavioural model: 0 = waiting for first window, 1 = searching, 2 = locked.
  int m_mode, m_hits, m_miss, m_code, m_step, m_dir, m_dir_seen, m_prev_mc;
  int m_sat;
  int hist[$];

  fmdll_lock_ctrl #(
    .CODE_W    (CODE_W),
    .CODE_INIT (CODE_INIT),
    .LOCK_CNT  (LOCK_CNT),
    .LOSS_CNT  (LOSS_CNT)
  ) dut (
    .clk_ext   (clk_ext),
    .rst_n     (rst_n),
    .M         (M),
    .N         (N),
    .M_counter (M_counter),
    .N_counter (N_counter),
    .dly_code  (dly_code),
    .Sel       (Sel),
    .lock      (lock),
    .sat       (sat)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hits = 0; m_miss = 0; m_code = CODE_INIT; m_sat = 0;
    m_step = 1 << (CODE_W - 2); m_dir = 0; m_dir_seen = 0; m_prev_mc = 0;
    hist.delete();
    repeat (4) hist.push_back(0);
  endtask

  // dir = +1 raises the code, -1 lowers it; result clipped to the code range.
  task automatic model_move(input int dir);
    int nxt;
`ifdef FMDLL_LOCK_CTRL_BINSRCH_EN
    if (m_dir_seen != 0 && dir != m_dir && m_step > 1) m_step = m_step / 2;
    m_dir = dir;
    m_dir_seen = 1;
    nxt = m_code + dir * m_step;
`else
    nxt = m_code + dir;
`endif
    if (nxt < 0) begin
      nxt = 0; m_sat = 1;
    end else if (nxt > CODE_MAX) begin
      nxt = CODE_MAX; m_sat = 1;
    end
    m_code = nxt;
  endtask

  // Predicts the outputs seen after the next clock edge.
  task automatic model_cycle(input int mc, input int nv);
    int samp;
    bit win, valid;
    hist.push_front(nv);
    samp  = hist[3];
    valid = (hist[2] == hist[3]);
    void'(hist.pop_back());
    win = (m_prev_mc == int'(M)) && (mc == 1);
    m_prev_mc = mc;
    m_sat = 0;
    if (win && valid) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (samp == int'(N)) begin
          m_hits++;
          if (m_hits == LOCK_CNT) begin
            m_mode = 2; m_hits = 0; m_miss = 0;
          end
        end else begin
          m_hits = 0;
          if (samp == 0) model_move(1);
          else if (samp < int'(N)) model_move(-1);
        end
      end else begin
        if (samp == int'(N)) begin
          m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_mode = 1; m_miss = 0; m_hits = 0;
            m_step = 1 << (CODE_W - 2); m_dir_seen = 0;
          end
        end
      end
    end
  endtask

  task automatic step_cycle(input int mc, input int nv);
    @(posedge clk_ext);
    #1;
    check_eq("dly_code", int'(dly_code), m_code);
    check_eq("lock", int'(lock), (m_mode == 2) ? 1 : 0);
    check_eq("Sel", int'(Sel), (m_mode == 2) ? 1 : 0);
    check_eq("sat", int'(sat), m_sat);
    M         = 2'(next_m);
    N         = 4'(next_n);
    M_counter = 2'(mc);
    N_counter = 4'(nv);
    model_cycle(mc, nv);
  endtask

  task automatic run_window(input int nval, input int glitch_at, input int gval);
    int m_len;
    m_len = next_m;
    for (int k = 1; k <= m_len; k++) begin
      step_cycle(k, (k == glitch_at) ? gval : nval);
    end
    win_idx++;
    $display("win %0d M=%0d N=%0d ncnt=%0d code=%0d lock=%0d sel=%0d sat_seen=%0d",
             win_idx, m_len, next_n, nval, dly_code, lock, Sel, m_sat);
  endtask

  task automatic apply_reset();
    @(posedge clk_ext);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_code", int'(dly_code), CODE_INIT);
    check_eq("arst_lock", int'(lock), 0);
    check_eq("arst_sel", int'(Sel), 0);
    check_eq("arst_sat", int'(sat), 0);
    M_counter = 2'd0;
    N_counter = 4'd0;
    model_reset();
    repeat (2) @(posedge clk_ext);
    @(negedge clk_ext);
    rst_n = 1'b1;
  endtask

  initial begin
    int nval, g_at, g_val, r;
    rst_n = 1'b0;
    M = 2'd3; N = 4'd4; M_counter = 2'd0; N_counter = 4'd0;
    model_reset();
    repeat (3) @(posedge clk_ext);
    #1;
    check_eq("rst_code", int'(dly_code), CODE_INIT);
    check_eq("rst_lock", int'(lock), 0);
    check_eq("rst_sel", int'(Sel), 0);
    check_eq("rst_sat", int'(sat), 0);
    @(negedge clk_ext);
    rst_n = 1'b1;

`ifdef FMDLL_LOCK_CTRL_BINSRCH_EN
    begin
      int bs_n[7]   = '{2, 0, 2, 0, 2, 0, 2};
      int bs_exp[7] = '{32, 16, 24, 20, 22, 21, 22};
      run_window(2, 0, 0);
      for (int i = 0; i < 7; i++) begin
        run_window(bs_n[i], 0, 0);
        check_eq("binsrch_code", int'(dly_code), bs_exp[i]);
      end
    end
`else
    // Slow windows step the code down by one per window.
    run_window(2, 0, 0);
    run_window(2, 0, 0);
    check_eq("idle_to_adjust_code", int'(dly_code), 32);
    run_window(2, 0, 0);
    check_eq("slow1_code", int'(dly_code), 31);
    run_window(4, 0, 0);
    check_eq("slow2_code", int'(dly_code), 30);
    // Four hit windows lead to lock one cycle after the fourth window end.
    repeat (3) run_window(4, 0, 0);
    check_eq("prelock_lock", int'(lock), 0);
    step_cycle(1, 3);
    check_eq("lock_at_win_end", int'(lock), 0);
    step_cycle(2, 3);
    check_eq("lock_rise", int'(lock), 1);
    check_eq("sel_rise", int'(Sel), 1);
    step_cycle(3, 3);
    win_idx++;
    // One miss then a hit keeps lock; two misses drop it.
    run_window(4, 0, 0);
    check_eq("miss1_lock", int'(lock), 1);
    run_window(3, 0, 0);
    check_eq("hit_after_miss_lock", int'(lock), 1);
    run_window(3, 0, 0);
    check_eq("miss1b_lock", int'(lock), 1);
    run_window(4, 0, 0);
    check_eq("loss_lock", int'(lock), 0);
    check_eq("loss_sel", int'(Sel), 0);
    check_eq("loss_code_hold", int'(dly_code), 30);
    // Drive the code to zero, then one more slow window saturates.
    repeat (31) run_window(2, 0, 0);
    check_eq("floor_code", int'(dly_code), 0);
    step_cycle(1, 2);
    check_eq("sat_before", int'(sat), 0);
    step_cycle(2, 2);
    check_eq("sat_pulse", int'(sat), 1);
    check_eq("sat_code", int'(dly_code), 0);
    step_cycle(3, 2);
    check_eq("sat_after", int'(sat), 0);
    win_idx++;
`endif

    // Randomized windows, including M/N changes and a mid-run reset.
    for (int w = 0; w < 300; w++) begin
      if (w % 50 == 0) begin
        next_m = $urandom_range(1, 3);
        next_n = $urandom_range(1, 15);
      end
      if (w == 150) apply_reset();
      r = $urandom_range(0, 9);
      if (r < 2) nval = 0;
      else if (r < 4) nval = (next_n > 1) ? $urandom_range(1, next_n - 1) : next_n;
      else nval = next_n;
      g_at = 0;
      g_val = 0;
      if ($urandom_range(0, 5) == 0) begin
        g_at  = $urandom_range(1, next_m);
        g_val = $urandom_range(0, next_n);
      end
      run_window(nval, g_at, g_val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmdll_lock_ctrl.md
Name: fmdll_lock_ctrl

Overview:
- Downstream consumer of the FMDLL clock counters, clocked by clk_ext.
- Samples the clk_out-domain N_counter at the end of each M-cycle reference window and compares the sample to N.
- Steps the delay-line code toward alignment, declares lock after consecutive hits and asserts Sel to freeze N counting.
- Drops lock after consecutive misses.

Parameters:
- CODE_W, 6, width of the delay-line control code.
- CODE_INIT, 32, dly_code value after reset (midscale).
- LOCK_CNT, 4, consecutive window hits required to enter LOCKED (1..15).
- LOSS_CNT, 2, consecutive window misses in LOCKED before relock (1..15).

Ports:
- clk_ext  in  1  reference clock; the block's only clock.
- rst_n  in  1  asynchronous active-low reset.
- M  in  2  reference window length in clk_ext cycles (upstream divisor).
- N  in  4  expected clk_out count per window (multiplication factor).
- M_counter  in  2  upstream clk_ext-domain window counter (1..M).
- N_counter  in  4  upstream clk_out-domain counter (0..N); asynchronous to clk_ext.
- dly_code  out  CODE_W  delay-line control code.
- Sel  out  1  freeze request to the upstream N counter; high only in LOCKED.
- lock  out  1  lock indicator.
- sat  out  1  pulse: requested step clipped at code 0 or max.

Behaviour:
- Clock and reset: one clock, clk_ext. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - dly_code = CODE_INIT.
  - Sel = 0, lock = 0, sat = 0.
  - Both counters = 0.
  - Synchronizer stages = 0.
  - State = IDLE.
- N_counter crossing:
  - 2-flop synchronizer on all 4 bits, followed by a stability register.
  - A sample is valid only when two consecutive synchronized values are equal. Otherwise the window is skipped with no action.
- Window end (win_end):
  - Registered M_counter == M and current M_counter == 1.
  - One-cycle strobe.
  - With M == 1: fires every cycle that M_counter == 1 after a cycle at 1.
- FSM (states IDLE, ADJUST, LOCKED), evaluated only on win_end with a valid sample:
  - IDLE: on the first win_end go to ADJUST. No code change.
  - ADJUST, sample == N: hit_cnt++. When hit_cnt reaches LOCK_CNT, go to LOCKED with lock = 1 and Sel = 1 on the next edge, and clear hit_cnt.
  - ADJUST, sample in 1..N-1: output is slow; dly_code -= step and hit_cnt = 0.
  - ADJUST, sample == 0: counter not yet running; dly_code += step and hit_cnt = 0.
  - LOCKED, sample == N: miss_cnt = 0.
  - LOCKED, any other valid sample: miss_cnt++. When it reaches LOSS_CNT, go to ADJUST with lock = 0, Sel = 0, and both counters cleared. dly_code holds.
- Step arithmetic:
  - Computed in CODE_W+1 bits.
  - Result clamped to the range 0 .. 2^CODE_W-1.
  - If clamping occurs, sat pulses for 1 cycle.
- Latency: dly_code, lock and Sel update on the clk_ext edge after win_end. The decision uses a sample that is 3 cycles old.
- Mid-operation changes:
  - An M or N change while LOCKED is treated as ordinary mismatches.
  - rst_n assertion at any time returns all state to the reset values immediately.
- Simultaneous events: a sat pulse coincides with the code update that caused it.

Optional Feature:
- Macro: FMDLL_LOCK_CTRL_BINSRCH_EN.
- Defined (binary search):
  - step starts at 2^(CODE_W-2) and halves each time the adjust direction reverses, with a minimum of 1.
  - step resets to 2^(CODE_W-2) when leaving LOCKED.
- Undefined: step is fixed at 1 (linear search).

Decomposition:
- Package fmdll_pkg:
  - state enum (IDLE, ADJUST, LOCKED).
  - CODE_W default.
  - direction enum (DIR_UP, DIR_DN).
- Sub-module fmdll_sync_bus: 2-flop synchronizer plus stability check, parameterized width, outputs data and valid.

Test Plan:
- Reset release: dly_code == 32, Sel == 0, lock == 0. First win_end moves IDLE->ADJUST with no code change.
- M=3, N=4, N_counter held at 2: dly_code steps 32->31->30, one step per window (linear build).
- N_counter held at 4 for 4 windows: lock and Sel rise one cycle after the 4th win_end.
- Locked, then N_counter at 3 for 2 windows: lock and Sel fall after the 2nd miss; 1 miss followed by a hit keeps lock.
- dly_code driven to 0, then another slow window: dly_code stays 0 and sat pulses for exactly 1 cycle.
- BINSRCH_EN defined, alternating slow/zero samples: steps are 16, 8, 4, 2, 1, 1, giving code 32->16->24->20->22->21->22.
